// File: rtl/priority_decoder_pkg.sv
// Shared definitions for the priority decoder: code/output widths, FSM states
// and the code-to-line decode.
package priority_decoder_pkg;

    localparam int CODE_W = 2;
    localparam int OUT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    function automatic logic [OUT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
        decode_onehot = OUT_W'(1) << code;
    endfunction

endpackage

// File: rtl/pd_fifo.sv
// Code queue for the priority decoder: power-of-two depth, wrapping pointers,
// occupancy count, first-word-fall-through read data.
module pd_fifo #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [CODE_W-1:0]        push_data,
    input  logic                     pop,
    output logic [CODE_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointer width equals log2(DEPTH), so the increment wraps modulo DEPTH.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/priority_decoder.sv
// Queued priority decoder: accepts 2-bit codes into a FIFO and drives them one at
// a time as registered one-hot lines, holding each until acknowledged.
module priority_decoder
    import priority_decoder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int GAP_EN = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [CODE_W-1:0]        code_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic                     ack_in,
    output logic                     o1_out,
    output logic                     o2_out,
    output logic                     o3_out,
    output logic                     o4_out,
    output logic                     busy_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CODE_W-1:0]    fifo_data;

    state_e               state_q, state_d;
    logic [OUT_W-1:0]     onehot_q, onehot_d;
    logic                 busy_q, busy_d;
    logic                 avail_q, avail_d;

    assign ready_out = !rst_in && !fifo_full;
    assign fifo_push = valid_in && ready_out;

    pd_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (fifo_push),
        .push_data (code_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count_out)
    );

    // avail_q lags the queue by one cycle, giving the two-edge accept-to-drive latency;
    // it is never set in a cycle that pops, so it cannot point at an empty queue.
    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        busy_d   = busy_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (avail_q) begin
                    fifo_pop = 1'b1;
                    onehot_d = decode_onehot(fifo_data);
                    busy_d   = 1'b1;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (ack_in) begin
                    onehot_d = '0;
                    busy_d   = 1'b0;
                    state_d  = (GAP_EN != 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                onehot_d = '0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
        avail_d = !fifo_empty && !fifo_pop;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            busy_q   <= 1'b0;
            avail_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            busy_q   <= busy_d;
            avail_q  <= avail_d;
        end
    end

    assign o1_out   = onehot_q[0];
    assign o2_out   = onehot_q[1];
    assign o3_out   = onehot_q[2];
    assign o4_out   = onehot_q[3];
    assign busy_out = busy_q;

endmodule
